// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU opcodes and FSM state encoding.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [3:0] ALU_OP_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters; undefined opcodes produce zero.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam int SHW = $clog2(DATA_W);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SUB:  result = a - b;
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SRA:  result = $signed(a) >>> shamt;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter around one shared ALU with registered operands and result;
// a single operation is in flight at a time.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no operation in flight; granted port may be accepted
//   EXEC  | operands registered, ALU result captured at next edge
//   RESP  | result held on rsp_* for the owner until it handshakes
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [7:0]            req_op,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_out,
    output logic                  rsp_zero,
    output logic                  rsp_illegal,
    output logic                  busy
);

    state_t            state, state_next;
    logic              last_grant;
    logic              owner;
    logic              grant;
    logic              accept;
    logic              rsp_done;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero_unused;

    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = FIXED_PRIO ? 1'b0 : ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    // rst_n gating keeps req_ready low while reset is asserted even if requests are held
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && rst_n && req_valid[grant])
            req_ready[grant] = 1'b1;
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state == RESP)
            rsp_valid[owner] = 1'b1;
    end

    assign accept   = |(req_valid & req_ready);
    assign rsp_done = rsp_valid[owner] & rsp_ready[owner];
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_out     <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= grant ? req_op[7:4] : req_op[3:0];
                a_q        <= grant ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                b_q        <= grant ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                owner      <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) begin
                rsp_out     <= alu_out;
                rsp_zero    <= (alu_out == '0);
                rsp_illegal <= (op_q > ALU_OP_MAX);
            end
        end
    end

    alu_share_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_out),
        .zero   (alu_zero_unused)
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a cycle model predicts grants and results,
// a second instance with fixed priority is checked during the contention phase.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [7:0]  req_op = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [1:0]  rsp_ready = 2'b11;

    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_out;
    logic        rsp_zero, rsp_illegal, busy;

    logic [1:0]  fp_req_ready, fp_rsp_valid;
    logic [31:0] fp_rsp_out;
    logic        fp_rsp_zero, fp_rsp_illegal, fp_busy;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_zero(rsp_zero),
        .rsp_illegal(rsp_illegal), .busy(busy)
    );

    alu_share_arbiter #(.DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(fp_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_out(fp_rsp_out), .rsp_zero(fp_rsp_zero),
        .rsp_illegal(fp_rsp_illegal), .busy(fp_busy)
    );

    typedef struct packed {
        logic        port;
        logic [31:0] out;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   m_st = 0;
    logic m_last = 1'b1;
    logic m_owner = 1'b0;
    logic fp_phase = 1'b0;
    int   fp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd6:    return a - b;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // cycle model: decisions made at negedge apply at the following posedge
    initial begin : monitor
        logic       g;
        logic [1:0] er;
        logic [1:0] ev;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_st   = 0;
                m_last = 1'b1;
                sb.delete();
            end else begin
                g  = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                er = (m_st == 0 && req_valid[g]) ? (2'b01 << g) : 2'b00;
                ev = (m_st == 2) ? (2'b01 << m_owner) : 2'b00;
                chk("busy", {63'd0, busy}, {63'd0, (m_st != 0)});
                chk("req_ready", {62'd0, req_ready}, {62'd0, er});
                chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, ev});
                if (m_st == 2) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        e = sb[0];
                        chk("rsp_out", {32'd0, rsp_out}, {32'd0, e.out});
                        chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, e.zero});
                        chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, e.ill});
                        if (rsp_ready[m_owner]) begin
                            void'(sb.pop_front());
                            m_st = 0;
                        end
                    end
                end else if (m_st == 1) begin
                    m_st = 2;
                end else if (er != 2'b00) begin
                    e.port = g;
                    e.out  = model_alu(g ? req_op[7:4] : req_op[3:0],
                                       g ? req_a[63:32] : req_a[31:0],
                                       g ? req_b[63:32] : req_b[31:0]);
                    e.zero = (e.out == 32'd0);
                    e.ill  = ((g ? req_op[7:4] : req_op[3:0]) > 4'd9);
                    sb.push_back(e);
                    m_owner = g;
                    m_last  = g;
                    m_st    = 1;
                    if (fp_phase) grant_log.push_back(g);
                end
                if (fp_phase) begin
                    chk("fp_req_ready1", {63'd0, fp_req_ready[1]}, 64'd0);
                    if (fp_rsp_valid != 2'b00) begin
                        chk("fp_rsp_valid", {62'd0, fp_rsp_valid}, 64'd1);
                        chk("fp_rsp_out", {32'd0, fp_rsp_out}, 64'd0);
                        if (rsp_ready[0]) fp_cnt++;
                    end
                end
            end
        end
    end

    task automatic do_op(input logic p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic ok;
        ok = 1'b0;
        if (p) begin
            req_op[7:4] = op; req_a[63:32] = a; req_b[63:32] = b;
        end else begin
            req_op[3:0] = op; req_a[31:0] = a; req_b[31:0] = b;
        end
        req_valid[p] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] o, output logic z, output logic il);
        logic ok;
        ok = 1'b0;
        o = '0; z = 1'b0; il = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                o = rsp_out; z = rsp_zero; il = rsp_illegal;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_st == 0 && sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] o;
        logic        z, il, ok;

        #1;
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_out", {32'd0, rsp_out}, 64'd0);
        chk("rst_rsp_zero", {63'd0, rsp_zero}, 64'd0);
        chk("rst_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // contention: both ports valid continuously
        req_op = {4'd8, 4'd6};
        req_a  = {32'hFFFF_FFFF, 32'd7};
        req_b  = {32'd1, 32'd7};
        fp_phase = 1'b1;
        req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (grant_log.size() >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("contention_timeout", 64'd0, 64'd1);
        req_valid = 2'b00;
        drain();
        repeat (4) @(negedge clk);
        fp_phase = 1'b0;
        if (grant_log.size() >= 4) begin
            chk("rr_grant0", {63'd0, grant_log[0]}, 64'd0);
            chk("rr_grant1", {63'd0, grant_log[1]}, 64'd1);
            chk("rr_grant2", {63'd0, grant_log[2]}, 64'd0);
            chk("rr_grant3", {63'd0, grant_log[3]}, 64'd1);
        end
        chk("fp_count", {63'd0, (fp_cnt >= 2)}, 64'd1);
        @(posedge clk);
        #1;

        // single op with latency check
        do_op(1'b0, 4'd2, 32'd5, 32'd3);
        @(negedge clk);
        chk("lat_exec", {62'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("lat_resp", {62'd0, rsp_valid}, 64'd1);
        chk("add_out", {32'd0, rsp_out}, 64'd8);
        chk("add_zero", {63'd0, rsp_zero}, 64'd0);
        @(negedge clk);
        chk("lat_idle", {63'd0, busy}, 64'd0);
        drain();

        // shift and wrap
        do_op(1'b0, 4'd4, 32'd1, 32'd31);
        wait_rsp(o, z, il);
        chk("sll_out", {32'd0, o}, 64'h8000_0000);
        drain();
        do_op(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd1);
        wait_rsp(o, z, il);
        chk("wrap_out", {32'd0, o}, 64'd0);
        chk("wrap_zero", {63'd0, z}, 64'd1);
        drain();

        // illegal opcode
        do_op(1'b0, 4'hF, 32'h1234, 32'h1234);
        wait_rsp(o, z, il);
        chk("ill_out", {32'd0, o}, 64'd0);
        chk("ill_zero", {63'd0, z}, 64'd1);
        chk("ill_flag", {63'd0, il}, 64'd1);
        drain();

        // backpressure on port 1 while port 0 waits; port 0 rsp_ready must be ignored
        rsp_ready = 2'b01;
        req_op = {4'd9, 4'd0};
        req_a  = {32'h8000_0000, 32'd3};
        req_b  = {32'd4, 32'd5};
        req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                chk("bp_grant", {62'd0, req_ready}, 64'd2);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("bp_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_rsp(o, z, il);
        chk("bp_out", {32'd0, o}, 64'hF800_0000);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_out", {32'd0, rsp_out}, 64'hF800_0000);
            chk("bp_hold_ready", {62'd0, req_ready}, 64'd0);
            chk("bp_hold_valid", {62'd0, rsp_valid}, 64'd2);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_port0_accepted", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain();

        // reset during EXEC
        do_op(1'b1, 4'd2, 32'd10, 32'd20);
        req_op = {4'd1, 4'd3};
        req_a  = {32'h0F0F_0000, 32'h00FF_00FF};
        req_b  = {32'h0000_F0F0, 32'h0F0F_0F0F};
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_req_ready", {62'd0, req_ready}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", {62'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain();

        chk("sb_empty", {32'd0, sb.size()}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
